// File: rtl/pc_sequencer.sv
// pc_sequencer: PC redirect arbiter and flush/stall sequencer for the program_counter.
//
// Arbitrates redirects from reset, interrupt and execute/writeback (branch, R15 write),
// then holds flush_out high for FLUSH_CYCLES cycles, counting the redirect cycle itself.
// All outputs are registered.
//
// Ports:
//   clk_in            - system clock, rising edge
//   rst_n_in          - asynchronous active-low reset
//   pc_in             - current PC from program_counter (captured on IRQ entry)
//   stall_in          - decode hazard stall; holds the PC in the following cycle
//   branch_req_in     - taken branch from execute
//   branch_addr_in    - branch target
//   r15_wr_in         - writeback writes R15
//   r15_data_in       - value written to R15
//   irq_in            - level interrupt request
//   irq_en_in         - interrupt enable
//   mux_sel_out       - 1 = program_counter loads addr_to_jmp_out
//   addr_to_jmp_out   - redirect target
//   pc_en_out         - PC advance enable
//   flush_out         - invalidate fetch/decode
//   irq_ack_out       - one-cycle interrupt acknowledge
//   irq_ret_addr_out  - PC captured at interrupt entry

module pc_sequencer #(
    parameter int unsigned        ADDR_W       = 8,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = 8'h00,
    parameter logic [ADDR_W-1:0]  IRQ_VECTOR   = 8'h18,
    parameter int unsigned        FLUSH_CYCLES = 2
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              stall_in,
    input  logic              branch_req_in,
    input  logic [ADDR_W-1:0] branch_addr_in,
    input  logic              r15_wr_in,
    input  logic [ADDR_W-1:0] r15_data_in,
    input  logic              irq_in,
    input  logic              irq_en_in,
    output logic              mux_sel_out,
    output logic [ADDR_W-1:0] addr_to_jmp_out,
    output logic              pc_en_out,
    output logic              flush_out,
    output logic              irq_ack_out,
    output logic [ADDR_W-1:0] irq_ret_addr_out
);

    localparam logic [1:0] StBoot  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StFlush = 2'd2;

    // Counter value loaded in the redirect cycle; it reaches 0 in the last flush cycle.
    localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              mux_sel_q, mux_sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pc_en_q, pc_en_d;
    logic              flush_q, flush_d;
    logic              irq_ack_q, irq_ack_d;
    logic [ADDR_W-1:0] ret_q, ret_d;

    logic irq_req;
    assign irq_req = irq_in & irq_en_in;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mux_sel_d = 1'b0;
        addr_d    = addr_q;
        pc_en_d   = 1'b1;
        flush_d   = 1'b1;
        irq_ack_d = 1'b0;
        ret_d     = ret_q;

        unique case (state_q)
            StRun: begin
                if (irq_req) begin
                    state_d   = StFlush;
                    cnt_d     = FlushInit;
                    mux_sel_d = 1'b1;
                    addr_d    = IRQ_VECTOR;
                    irq_ack_d = 1'b1;
                    ret_d     = pc_in;
                end else if (branch_req_in) begin
                    state_d   = StFlush;
                    cnt_d     = FlushInit;
                    mux_sel_d = 1'b1;
                    addr_d    = branch_addr_in;
                end else if (r15_wr_in) begin
                    state_d   = StFlush;
                    cnt_d     = FlushInit;
                    mux_sel_d = 1'b1;
                    addr_d    = r15_data_in;
                end else begin
                    flush_d = 1'b0;
                    pc_en_d = ~stall_in;
                end
            end
            // The reset cycle is the redirect to RESET_VECTOR, so BOOT counts down like FLUSH.
            StBoot, StFlush: begin
                if (cnt_q == 3'd0) begin
                    state_d = StRun;
                    flush_d = 1'b0;
                end else begin
                    state_d = StFlush;
                    cnt_d   = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = StBoot;
                cnt_d   = FlushInit;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= StBoot;
            cnt_q     <= FlushInit;
            mux_sel_q <= 1'b1;
            addr_q    <= RESET_VECTOR;
            pc_en_q   <= 1'b1;
            flush_q   <= 1'b1;
            irq_ack_q <= 1'b0;
            ret_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mux_sel_q <= mux_sel_d;
            addr_q    <= addr_d;
            pc_en_q   <= pc_en_d;
            flush_q   <= flush_d;
            irq_ack_q <= irq_ack_d;
            ret_q     <= ret_d;
        end
    end

    assign mux_sel_out      = mux_sel_q;
    assign addr_to_jmp_out  = addr_q;
    assign pc_en_out        = pc_en_q;
    assign flush_out        = flush_q;
    assign irq_ack_out      = irq_ack_q;
    assign irq_ret_addr_out = ret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer with a cycle-level reference model
// compared on every falling edge, plus literal expectations at key points.

module tb_pc_sequencer;

    localparam int unsigned AW = 8;
    localparam logic [7:0]  RV = 8'h00;
    localparam logic [7:0]  IV = 8'h18;
    localparam int          FC = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] pc;
    logic          stall, branch, r15, irq, irq_en;
    logic [AW-1:0] baddr, rdata;
    logic          mux_sel, pc_en, flush, ack;
    logic [AW-1:0] jaddr, ret;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .ADDR_W       (AW),
        .RESET_VECTOR (RV),
        .IRQ_VECTOR   (IV),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .pc_in            (pc),
        .stall_in         (stall),
        .branch_req_in    (branch),
        .branch_addr_in   (baddr),
        .r15_wr_in        (r15),
        .r15_data_in      (rdata),
        .irq_in           (irq),
        .irq_en_in        (irq_en),
        .mux_sel_out      (mux_sel),
        .addr_to_jmp_out  (jaddr),
        .pc_en_out        (pc_en),
        .flush_out        (flush),
        .irq_ack_out      (ack),
        .irq_ret_addr_out (ret)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks how many flush-high cycles remain rather than FSM states.
    logic       m_mux, m_pcen, m_flush, m_ack;
    logic [7:0] m_addr, m_ret;
    int         m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mux <= 1'b1; m_addr <= RV; m_pcen <= 1'b1; m_flush <= 1'b1;
            m_ack <= 1'b0; m_ret <= 8'h00; m_left <= FC - 1;
        end else begin
            m_ack <= 1'b0;
            m_mux <= 1'b0;
            m_pcen <= 1'b1;
            if (m_flush) begin
                if (m_left > 0) m_left <= m_left - 1;
                else m_flush <= 1'b0;
            end else if (irq && irq_en) begin
                m_mux <= 1'b1; m_addr <= IV; m_flush <= 1'b1; m_left <= FC - 1;
                m_ack <= 1'b1; m_ret <= pc;
            end else if (branch) begin
                m_mux <= 1'b1; m_addr <= baddr; m_flush <= 1'b1; m_left <= FC - 1;
            end else if (r15) begin
                m_mux <= 1'b1; m_addr <= rdata; m_flush <= 1'b1; m_left <= FC - 1;
            end else begin
                m_pcen <= ~stall;
            end
        end
    end

    always @(negedge clk) begin
        check("model mux_sel", {31'd0, mux_sel}, {31'd0, m_mux});
        check("model addr", {24'd0, jaddr}, {24'd0, m_addr});
        check("model pc_en", {31'd0, pc_en}, {31'd0, m_pcen});
        check("model flush", {31'd0, flush}, {31'd0, m_flush});
        check("model irq_ack", {31'd0, ack}, {31'd0, m_ack});
        check("model ret_addr", {24'd0, ret}, {24'd0, m_ret});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, " mux_sel"}, {31'd0, mux_sel}, 32'd1);
        check({tag, " addr"}, {24'd0, jaddr}, 32'h00);
        check({tag, " pc_en"}, {31'd0, pc_en}, 32'd1);
        check({tag, " flush"}, {31'd0, flush}, 32'd1);
        check({tag, " irq_ack"}, {31'd0, ack}, 32'd0);
        check({tag, " ret"}, {24'd0, ret}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; pc = 8'h40; stall = 0; branch = 0; r15 = 0; irq = 0; irq_en = 1;
        baddr = 0; rdata = 0;
        repeat (3) step();
        chk_reset_vals("reset");

        // Reset release: one redirect cycle, flush for two cycles total.
        rst_n = 1'b1;
        step();
        check("boot mux", {31'd0, mux_sel}, 32'd0);
        check("boot flush", {31'd0, flush}, 32'd1);
        step();
        check("run flush", {31'd0, flush}, 32'd0);
        check("run pc_en", {31'd0, pc_en}, 32'd1);

        // Branch to 100.
        branch = 1; baddr = 8'd100;
        step(); branch = 0;
        check("br mux", {31'd0, mux_sel}, 32'd1);
        check("br addr", {24'd0, jaddr}, 32'd100);
        check("br flush", {31'd0, flush}, 32'd1);
        step();
        check("br mux2", {31'd0, mux_sel}, 32'd0);
        check("br flush2", {31'd0, flush}, 32'd1);
        step();
        check("br flush3", {31'd0, flush}, 32'd0);

        // Simultaneous requests: IRQ wins.
        pc = 8'd42; irq = 1; irq_en = 1; branch = 1; baddr = 8'd10; r15 = 1; rdata = 8'd50;
        step(); irq = 0; branch = 0; r15 = 0;
        check("sim addr", {24'd0, jaddr}, 32'h18);
        check("sim ack", {31'd0, ack}, 32'd1);
        check("sim ret", {24'd0, ret}, 32'd42);
        check("sim mux", {31'd0, mux_sel}, 32'd1);
        step();
        check("sim ack2", {31'd0, ack}, 32'd0);
        check("sim ret hold", {24'd0, ret}, 32'd42);
        step();

        // Requests during flush are ignored.
        branch = 1; baddr = 8'd10;
        step(); baddr = 8'd77;
        check("fl addr", {24'd0, jaddr}, 32'd10);
        step();
        check("fl mux", {31'd0, mux_sel}, 32'd0);
        step(); branch = 0;
        check("fl mux2", {31'd0, mux_sel}, 32'd0);
        check("fl addr hold", {24'd0, jaddr}, 32'd10);
        step();
        check("fl mux3", {31'd0, mux_sel}, 32'd0);

        // IRQ held through flush is taken on first RUN edge.
        branch = 1; baddr = 8'd30;
        step(); branch = 0; irq = 1; irq_en = 1;
        check("ih addr", {24'd0, jaddr}, 32'd30);
        step();
        check("ih ack0", {31'd0, ack}, 32'd0);
        step();
        check("ih ack1", {31'd0, ack}, 32'd0);
        check("ih flush", {31'd0, flush}, 32'd0);
        step(); irq = 0;
        check("ih ack", {31'd0, ack}, 32'd1);
        check("ih addr2", {24'd0, jaddr}, 32'h18);
        step(); step();

        // Stall for three cycles.
        pc = 8'h55; stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall pc_en", {31'd0, pc_en}, 32'd0);
        end
        stall = 0;
        step();
        check("unstall pc_en", {31'd0, pc_en}, 32'd1);

        // Redirect overrides stall.
        stall = 1; branch = 1; baddr = 8'd20;
        step(); stall = 0; branch = 0;
        check("sb mux", {31'd0, mux_sel}, 32'd1);
        check("sb pc_en", {31'd0, pc_en}, 32'd1);
        check("sb addr", {24'd0, jaddr}, 32'd20);
        step(); step();

        // Masked interrupt.
        irq = 1; irq_en = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mask ack", {31'd0, ack}, 32'd0);
            check("mask mux", {31'd0, mux_sel}, 32'd0);
        end
        irq = 0; irq_en = 1;

        // Reset during flush.
        branch = 1; baddr = 8'd5;
        step(); branch = 0;
        step();
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        step(); step();
        rst_n = 1'b1;
        step(); step();
        check("post rst flush", {31'd0, flush}, 32'd0);

        // Mixed traffic checked by the model.
        for (int i = 0; i < 60; i++) begin
            stall  = ($urandom_range(0, 3) == 0);
            branch = ($urandom_range(0, 4) == 0);
            baddr  = 8'($urandom);
            r15    = ($urandom_range(0, 4) == 0);
            rdata  = 8'($urandom);
            irq    = ($urandom_range(0, 5) == 0);
            irq_en = ($urandom_range(0, 1) == 0);
            pc     = 8'($urandom);
            step();
        end
        stall = 0; branch = 0; r15 = 0; irq = 0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
